vfetch: RTL

Video framebuffer fetcher: the write-side master for the video queue. It reads the framebuffer from memory in fixed-length bursts whenever the queue reports almost-empty, and pushes the returned 32-bit words into the queue write port. The frame pointer restarts on each vertical sync, so the scanout side always receives words in framebuffer order starting at `base_addr`. It sits between the memory arbiter's read port and the queue, in the memory clock domain.

---
 rtl/vfetch.sv | 136 +++++++++++++
 1 files changed

// File: rtl/vfetch.sv
// vfetch - video framebuffer fetcher (write-side master of the video queue).
//
// When the queue reports almost-empty, the block reads the framebuffer from
// memory in fixed-length bursts and pushes each returned 32-bit word into the
// queue write port. A rising edge of vsync restarts the frame pointer at
// base_addr once any burst in flight has completed. Bursts are never aborted.
// Everything runs in the memory clock domain.
//
// Parameters:
//   burst_len    words per memory burst (power of two, 1..64)
//   base_addr    byte address of the first framebuffer word
//   frame_words  words per frame (multiple of burst_len)
//
// Ports:
//   clk                single clock (memory side and queue write side)
//   rst                synchronous reset, active low
//   enable             0 blocks new bursts; an in-flight burst completes
//   vsync              level input; its rising edge requests a frame restart
//   fifo_almost_empty  queue AlmostEmpty
//   fifo_wr            queue write enable (registered)
//   fifo_data          queue write data (registered, holds when fifo_wr=0)
//   mem_req            burst read request (registered)
//   mem_addr           burst start byte address, 4-byte aligned (registered)
//   mem_ack            request accepted
//   mem_rvalid         read beat valid
//   mem_rdata          read beat data

module vfetch #(
    parameter int unsigned burst_len   = 8,
    parameter logic [31:0] base_addr   = 32'h000E7F00,
    parameter int unsigned frame_words = 24576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        vsync,
    input  logic        fifo_almost_empty,
    output logic        fifo_wr,
    output logic [31:0] fifo_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned PTR_W  = (frame_words > 1) ? $clog2(frame_words) : 1;
    localparam int unsigned PTR_W1 = PTR_W + 1;
    localparam int unsigned CNT_W  = (burst_len > 1) ? $clog2(burst_len) : 1;

    localparam logic [PTR_W:0]   PTR_STEP  = PTR_W1'(burst_len);
    localparam logic [PTR_W:0]   PTR_END   = PTR_W1'(frame_words);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(burst_len - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   word_ptr;
    logic [CNT_W-1:0]   beat_cnt;
    logic               restart_pend;
    logic               vsync_q;

    logic               vsync_rise;
    logic [PTR_W:0]     ptr_next;
    logic [31:0]        next_addr;

    always_comb begin
        vsync_rise = vsync & ~vsync_q;
        // One extra bit so the end-of-frame compare works when frame_words
        // is an exact power of two.
        ptr_next   = {1'b0, word_ptr} + PTR_STEP;
        next_addr  = base_addr + 32'({word_ptr, 2'b00});
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            word_ptr     <= '0;
            beat_cnt     <= '0;
            restart_pend <= 1'b0;
            vsync_q      <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            fifo_wr      <= 1'b0;
            fifo_data    <= '0;
        end else begin
            fifo_wr <= 1'b0;
            vsync_q <= vsync;
            if (vsync_rise) begin
                restart_pend <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (restart_pend) begin
                        // Restart consumes a cycle in IDLE; an edge arriving in
                        // this same cycle stays pending.
                        word_ptr     <= '0;
                        restart_pend <= vsync_rise;
                    end else if (enable && fifo_almost_empty) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= next_addr;
                    end
                end

                REQ: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        beat_cnt <= '0;
                        state    <= DATA;
                    end
                end

                DATA: begin
                    if (mem_rvalid) begin
                        fifo_wr   <= 1'b1;
                        fifo_data <= mem_rdata;
                        beat_cnt  <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            word_ptr <= (ptr_next == PTR_END) ? '0 : ptr_next[PTR_W-1:0];
                            state    <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
